// File: rtl/dbus_mmio_responder.sv
// rtl/dbus_mmio_responder.sv - data-bus responder: byte RAM, MMIO page (cycle, GPIO, console FIFO), optional timer compare (DBUS_TIMER_CMP_EN)
module dbus_mmio_responder #(
   parameter int          RAM_WORDS  = 1024,
   parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] daddr,
   input  logic [31:0] dwdata,
   input  logic [3:0]  we,
   output logic [31:0] drdata,
   output logic [31:0] gpio_out,
   output logic [7:0]  con_data,
   output logic        con_valid,
   input  logic        con_ready,
   output logic        timer_irq
);

   localparam int          AW        = $clog2(RAM_WORDS);
   localparam int          FAW       = $clog2(FIFO_DEPTH);
   localparam int          CW        = FAW + 1;
   localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;

   localparam logic [7:0] OFF_CYCLE = 8'h00;
   localparam logic [7:0] OFF_GPIO  = 8'h04;
   localparam logic [7:0] OFF_CDATA = 8'h08;
   localparam logic [7:0] OFF_CSTAT = 8'h0C;
   localparam logic [7:0] OFF_CMP   = 8'h10;

   logic [31:0]    ram [RAM_WORDS];
   logic [7:0]     fifo_mem [FIFO_DEPTH];

   logic [31:0]    cycle;
   logic [31:0]    gpio;
   logic [FAW-1:0] rd_ptr;
   logic [FAW-1:0] wr_ptr;
   logic [CW-1:0]  count;
   logic           ovf;

   logic           is_ram;
   logic           is_mmio;
   logic [7:0]     off;
   logic [AW-1:0]  ram_idx;
   logic           full;
   logic           empty;
   logic [2:0]     count3;
   logic           push;
   logic           pop;
   logic           push_ok;
   logic           ovf_clr;

   // Address decode; RAM wins over MMIO, low two address bits are ignored
   always_comb begin
      is_ram  = ({1'b0, daddr} < RAM_BYTES);
      is_mmio = !is_ram && (daddr[31:8] == MMIO_BASE[31:8]);
      off     = {daddr[7:2], 2'b00};
      ram_idx = daddr[AW+1:2];
   end

   assign full      = (count == CW'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign count3    = 3'(count);
   assign con_valid = !empty;
   assign con_data  = fifo_mem[rd_ptr];
   assign gpio_out  = gpio;

   assign pop     = con_valid && con_ready;
   assign push    = is_mmio && (off == OFF_CDATA) && we[0];
   assign push_ok = push && (!full || pop);
   assign ovf_clr = is_mmio && (off == OFF_CSTAT) && we[0] && dwdata[2];

   // RAM byte-lane writes; contents survive reset
   always_ff @(posedge clk) begin
      if (is_ram) begin
         for (int i = 0; i < 4; i++) begin
            if (we[i]) ram[ram_idx][8*i +: 8] <= dwdata[8*i +: 8];
         end
      end
   end

   // Console FIFO storage; data is don't-care after reset so it is not cleared
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= dwdata[7:0];
   end

   // Cycle counter, GPIO register and console FIFO control state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle  <= '0;
         gpio   <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         cycle <= cycle + 32'd1;
         if (is_mmio && (off == OFF_GPIO)) begin
            for (int i = 0; i < 4; i++) begin
               if (we[i]) gpio[8*i +: 8] <= dwdata[8*i +: 8];
            end
         end
         if (push_ok) wr_ptr <= wr_ptr + FAW'(1);
         if (pop)     rd_ptr <= rd_ptr + FAW'(1);
         if (push_ok && !pop)      count <= count + CW'(1);
         else if (pop && !push_ok) count <= count - CW'(1);
         if (push && full && !pop) ovf <= 1'b1;
         else if (ovf_clr)         ovf <= 1'b0;
      end
   end

`ifdef DBUS_TIMER_CMP_EN
   logic [31:0] cmp;
   logic        irq;
   logic        cmp_wr;

   assign cmp_wr    = is_mmio && (off == OFF_CMP) && (we != 4'b0000);
   assign timer_irq = irq;

   // Compare register and sticky interrupt; a CMP write beats a same-cycle match
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmp <= 32'hFFFF_FFFF;
         irq <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (cmp_wr && we[i]) cmp[8*i +: 8] <= dwdata[8*i +: 8];
         end
         if (cmp_wr)              irq <= 1'b0;
         else if (cycle == cmp)   irq <= 1'b1;
      end
   end
`else
   assign timer_irq = 1'b0;
`endif

   // Combinational read mux
   always_comb begin
      drdata = '0;
      if (is_ram) begin
         drdata = ram[ram_idx];
      end else if (is_mmio) begin
         case (off)
            OFF_CYCLE: drdata = cycle;
            OFF_GPIO:  drdata = gpio;
            OFF_CSTAT: drdata = {25'b0, count3, 1'b0, ovf, full, empty};
`ifdef DBUS_TIMER_CMP_EN
            OFF_CMP:   drdata = cmp;
`endif
            default:   drdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_dbus_mmio_responder.sv
// tb/tb_dbus_mmio_responder.sv - directed self-checking bench for dbus_mmio_responder
module tb_dbus_mmio_responder;

   localparam logic [31:0] A_CYCLE = 32'hFFFF_0000;
   localparam logic [31:0] A_GPIO  = 32'hFFFF_0004;
   localparam logic [31:0] A_CDATA = 32'hFFFF_0008;
   localparam logic [31:0] A_CSTAT = 32'hFFFF_000C;
   localparam logic [31:0] A_CMP   = 32'hFFFF_0010;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] daddr = '0;
   logic [31:0] dwdata = '0;
   logic [3:0]  we = '0;
   logic [31:0] drdata;
   logic [31:0] gpio_out;
   logic [7:0]  con_data;
   logic        con_valid;
   logic        con_ready = 1'b0;
   logic        timer_irq;

   int checks = 0;
   int failures = 0;

   dbus_mmio_responder dut (
      .clk       (clk),
      .reset     (reset),
      .daddr     (daddr),
      .dwdata    (dwdata),
      .we        (we),
      .drdata    (drdata),
      .gpio_out  (gpio_out),
      .con_data  (con_data),
      .con_valid (con_valid),
      .con_ready (con_ready),
      .timer_irq (timer_irq)
   );

   always #5 clk = ~clk;

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      @(negedge clk);
      daddr = a; dwdata = d; we = w;
      @(negedge clk);
      we = 4'b0000;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      we = 4'b0000; daddr = a;
      #1;
      d = drdata;
   endtask

   task automatic test_reset();
      logic [31:0] r;
      #1;
      checks++; if (gpio_out !== 32'h0) begin failures++; $display("FAIL reset_gpio got=%h exp=%h", gpio_out, 32'h0); end
      checks++; if (con_valid !== 1'b0) begin failures++; $display("FAIL reset_con_valid got=%b exp=0", con_valid); end
      checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", timer_irq); end
      bus_read(A_CYCLE, r);
      checks++; if (r !== 32'h0) begin failures++; $display("FAIL reset_cycle got=%h exp=%h", r, 32'h0); end
      bus_read(A_CSTAT, r);
      checks++; if (r !== 32'h1) begin failures++; $display("FAIL reset_cstat got=%h exp=%h", r, 32'h1); end
`ifdef DBUS_TIMER_CMP_EN
      bus_read(A_CMP, r);
      checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_cmp got=%h exp=%h", r, 32'hFFFF_FFFF); end
`endif
   endtask

   task automatic test_cycle();
      logic [31:0] c0, c1;
      @(negedge clk);
      daddr = A_CYCLE;
      reset = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checks++; if (drdata !== 32'd10) begin failures++; $display("FAIL cycle_10 got=%0d exp=10", drdata); end
      @(negedge clk);
      daddr = A_CYCLE; #1; c0 = drdata;
      we = 4'b1111; dwdata = 32'h0;
      @(negedge clk);
      we = 4'b0000; #1; c1 = drdata;
      checks++; if (c1 !== c0 + 32'd1) begin failures++; $display("FAIL cycle_write_ignored got=%h exp=%h", c1, c0 + 32'd1); end
   endtask

   task automatic test_ram();
      logic [31:0] r;
      bus_write(32'h10, 32'hDEADBEEF, 4'b1111);
      bus_write(32'h10, 32'h0000_5500, 4'b0010);
      bus_read(32'h10, r);
      checks++; if (r !== 32'hDEAD55EF) begin failures++; $display("FAIL ram_byte got=%h exp=%h", r, 32'hDEAD55EF); end
      bus_read(32'h12, r);
      checks++; if (r !== 32'hDEAD55EF) begin failures++; $display("FAIL ram_unaligned got=%h exp=%h", r, 32'hDEAD55EF); end
      @(negedge clk);
      daddr = 32'h10; dwdata = 32'hCAFEF00D; we = 4'b1111;
      #1;
      checks++; if (drdata !== 32'hDEAD55EF) begin failures++; $display("FAIL ram_rdw_old got=%h exp=%h", drdata, 32'hDEAD55EF); end
      @(negedge clk);
      we = 4'b0000; #1;
      checks++; if (drdata !== 32'hCAFEF00D) begin failures++; $display("FAIL ram_rdw_new got=%h exp=%h", drdata, 32'hCAFEF00D); end
      bus_write(32'h0, 32'h1111_1111, 4'b1111);
      bus_write(32'hFFC, 32'h0BAD_C0DE, 4'b1111);
      bus_write(32'h1000, 32'hFFFF_FFFF, 4'b1111);
      bus_read(32'h0, r);
      checks++; if (r !== 32'h1111_1111) begin failures++; $display("FAIL ram_no_alias got=%h exp=%h", r, 32'h1111_1111); end
      bus_read(32'hFFC, r);
      checks++; if (r !== 32'h0BAD_C0DE) begin failures++; $display("FAIL ram_last_word got=%h exp=%h", r, 32'h0BAD_C0DE); end
      bus_read(32'h1000, r);
      checks++; if (r !== 32'h0) begin failures++; $display("FAIL ram_past_end got=%h exp=0", r); end
   endtask

   task automatic test_unmapped_gpio();
      logic [31:0] r;
      bus_write(32'h8000_0000, 32'h1234, 4'b1111);
      bus_read(32'h8000_0000, r);
      checks++; if (r !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%h exp=0", r); end
      checks++; if (gpio_out !== 32'h0) begin failures++; $display("FAIL unmapped_gpio got=%h exp=0", gpio_out); end
      bus_read(32'h10, r);
      checks++; if (r !== 32'hCAFEF00D) begin failures++; $display("FAIL unmapped_ram got=%h exp=%h", r, 32'hCAFEF00D); end
      @(negedge clk);
      daddr = A_GPIO; dwdata = 32'hA5; we = 4'b1111;
      #1;
      checks++; if (gpio_out !== 32'h0) begin failures++; $display("FAIL gpio_before_edge got=%h exp=0", gpio_out); end
      @(posedge clk); #1;
      checks++; if (gpio_out !== 32'hA5) begin failures++; $display("FAIL gpio_write got=%h exp=%h", gpio_out, 32'hA5); end
      @(negedge clk);
      we = 4'b0000;
      bus_write(A_GPIO, 32'hFFFF_33FF, 4'b0010);
      checks++; if (gpio_out !== 32'h33A5) begin failures++; $display("FAIL gpio_byte got=%h exp=%h", gpio_out, 32'h33A5); end
      bus_read(A_GPIO, r);
      checks++; if (r !== 32'h33A5) begin failures++; $display("FAIL gpio_read got=%h exp=%h", r, 32'h33A5); end
      bus_read(32'hFFFF_0020, r);
      checks++; if (r !== 32'h0) begin failures++; $display("FAIL mmio_hole got=%h exp=0", r); end
   endtask

   task automatic test_fifo_overflow();
      logic [31:0] r;
      con_ready = 1'b0;
      for (int i = 0; i < 5; i++) bus_write(A_CDATA, 32'h41 + 32'(i), 4'b0001);
      bus_read(A_CSTAT, r);
      checks++; if (r !== 32'h46) begin failures++; $display("FAIL ovf_stat got=%h exp=%h", r, 32'h46); end
      bus_read(A_CDATA, r);
      checks++; if (r !== 32'h0) begin failures++; $display("FAIL cdata_read got=%h exp=0", r); end
      checks++; if (con_data !== 8'h41) begin failures++; $display("FAIL ovf_head got=%h exp=%h", con_data, 8'h41); end
      @(negedge clk);
      con_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (con_valid !== 1'b1 || con_data !== 8'h41 + 8'(i)) begin failures++; $display("FAIL ovf_pop%0d got=%h/%b exp=%h/1", i, con_data, con_valid, 8'h41 + 8'(i)); end
         @(negedge clk);
      end
      con_ready = 1'b0;
      #1;
      checks++; if (con_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%b exp=0", con_valid); end
      bus_read(A_CSTAT, r);
      checks++; if (r !== 32'h5) begin failures++; $display("FAIL ovf_sticky got=%h exp=%h", r, 32'h5); end
      bus_write(A_CSTAT, 32'h4, 4'b0001);
      bus_read(A_CSTAT, r);
      checks++; if (r !== 32'h1) begin failures++; $display("FAIL ovf_clear got=%h exp=%h", r, 32'h1); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r;
      logic [7:0]  exp_b [4];
      exp_b[0] = 8'h11; exp_b[1] = 8'h12; exp_b[2] = 8'h13; exp_b[3] = 8'h5A;
      con_ready = 1'b0;
      for (int i = 0; i < 4; i++) bus_write(A_CDATA, 32'h10 + 32'(i), 4'b0001);
      bus_read(A_CSTAT, r);
      checks++; if (r !== 32'h42) begin failures++; $display("FAIL full_stat got=%h exp=%h", r, 32'h42); end
      @(negedge clk);
      con_ready = 1'b1; daddr = A_CDATA; dwdata = 32'h5A; we = 4'b0001;
      @(negedge clk);
      we = 4'b0000; con_ready = 1'b0;
      bus_read(A_CSTAT, r);
      checks++; if (r !== 32'h42) begin failures++; $display("FAIL pushpop_stat got=%h exp=%h", r, 32'h42); end
      @(negedge clk);
      con_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (con_data !== exp_b[i]) begin failures++; $display("FAIL pushpop_order%0d got=%h exp=%h", i, con_data, exp_b[i]); end
         @(negedge clk);
      end
      con_ready = 1'b0;
      bus_read(A_CSTAT, r);
      checks++; if (r !== 32'h1) begin failures++; $display("FAIL pushpop_empty got=%h exp=%h", r, 32'h1); end
   endtask

   task automatic test_async_reset();
      bus_write(A_CDATA, 32'h77, 4'b0001);
      checks++; if (con_valid !== 1'b1) begin failures++; $display("FAIL prereset_valid got=%b exp=1", con_valid); end
      @(negedge clk);
      daddr = A_CYCLE;
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      checks++; if (drdata !== 32'h0) begin failures++; $display("FAIL areset_cycle got=%h exp=0", drdata); end
      checks++; if (gpio_out !== 32'h0) begin failures++; $display("FAIL areset_gpio got=%h exp=0", gpio_out); end
      checks++; if (con_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b exp=0", con_valid); end
      daddr = 32'h10; #1;
      checks++; if (drdata !== 32'hCAFEF00D) begin failures++; $display("FAIL areset_ram got=%h exp=%h", drdata, 32'hCAFEF00D); end
      daddr = A_CSTAT; #1;
      checks++; if (drdata !== 32'h1) begin failures++; $display("FAIL areset_cstat got=%h exp=%h", drdata, 32'h1); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_timer();
      logic [31:0] r;
`ifdef DBUS_TIMER_CMP_EN
      bit found;
      found = 1'b0;
      bus_write(A_CMP, 32'd50, 4'b1111);
      @(negedge clk);
      daddr = A_CYCLE;
      for (int k = 0; k < 200 && !found; k++) begin
         @(posedge clk); #1;
         if (drdata == 32'd50) found = 1'b1;
      end
      checks++; if (!found) begin failures++; $display("FAIL timer_reach got=timeout exp=cycle_50"); end
      checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL timer_early got=%b exp=0", timer_irq); end
      @(posedge clk); #1;
      checks++; if (timer_irq !== 1'b1) begin failures++; $display("FAIL timer_rise got=%b exp=1", timer_irq); end
      repeat (5) @(posedge clk);
      #1;
      checks++; if (timer_irq !== 1'b1) begin failures++; $display("FAIL timer_hold got=%b exp=1", timer_irq); end
      bus_write(A_CMP, 32'd1000, 4'b1111);
      checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL timer_clear got=%b exp=0", timer_irq); end
      bus_read(A_CMP, r);
      checks++; if (r !== 32'd1000) begin failures++; $display("FAIL timer_cmp_read got=%h exp=%h", r, 32'd1000); end
`else
      bus_write(A_CMP, 32'd50, 4'b1111);
      bus_read(A_CMP, r);
      checks++; if (r !== 32'h0) begin failures++; $display("FAIL nocmp_read got=%h exp=0", r); end
      repeat (60) @(posedge clk);
      #1;
      checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL nocmp_irq got=%b exp=0", timer_irq); end
`endif
   endtask

   initial begin
      test_reset();
      test_cycle();
      test_ram();
      test_unmapped_gpio();
      test_fifo_overflow();
      test_back_to_back();
      test_async_reset();
      test_timer();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
